// File: rtl/pgm_video_pkg.sv
// Shared types and constants for the PGM video fetch blocks: fetch FSM states,
// tile entry layout, text map geometry and attribute word bit positions.
package pgm_video_pkg;

   localparam int MAP_W      = 64;
   localparam int MAP_H      = 32;
   localparam int MAP_X_BITS = $clog2(MAP_W);
   localparam int MAP_Y_BITS = $clog2(MAP_H);

   localparam int ATTR_COLOR_LSB = 1;
   localparam int ATTR_COLOR_MSB = 5;
   localparam int ATTR_FLIPX_BIT = 6;
   localparam int ATTR_FLIPY_BIT = 7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_CODE = 3'd1,
      ST_RD_ATTR = 3'd2,
      ST_LATCH   = 3'd3,
      ST_EMIT    = 3'd4
   } fetch_state_t;

   typedef struct packed {
      logic [15:0] code;
      logic [4:0]  color;
      logic        flipx;
      logic [2:0]  row;
   } tile_entry_t;

endpackage

// File: rtl/pgm_text_fetch.sv
// Text-layer tile fetcher: walks one scanline of the 64x32 text map and emits
// NUM_TILES entries over valid/ready. Optional macro PGM_TX_FLIPY_EN enables attr[7] Y-flip.
module pgm_text_fetch
   import pgm_video_pkg::*;
#(
   parameter logic [12:0] TX_BASE   = 13'h1000,
   parameter int          NUM_TILES = 57
) (
   input  logic        fixed_20m_clk,
   input  logic        reset_n,
   input  logic        line_start,
   input  logic [8:0]  vline,
   input  logic [15:0] scroll_x,
   input  logic [15:0] scroll_y,
   output logic [12:0] vram_addr,
   input  logic [15:0] vram_dout,
   output logic        tile_valid,
   input  logic        tile_ready,
   output logic [15:0] tile_code,
   output logic [4:0]  tile_color,
   output logic        tile_flipx,
   output logic [2:0]  tile_row,
   output logic [2:0]  tile_fine_x,
   output logic        line_done,
   output logic [2:0]  dbg_state
);

   // Handshake: an entry transfers on a rising edge where tile_valid && tile_ready;
   // while tile_valid is high and tile_ready low every tile_* output is held.

   fetch_state_t             r_state;
   fetch_state_t             w_state_nxt;
   logic [MAP_Y_BITS-1:0]    r_ty;
   logic [2:0]               r_row;
   logic [MAP_X_BITS-1:0]    r_tx0;
   logic [2:0]               r_fine_x;
   logic [7:0]               r_cnt;
   tile_entry_t              r_entry;
   logic [12:0]              r_addr_hold;

   logic [7:0]               w_y;
   logic [MAP_X_BITS-1:0]    w_tx;
   logic [12:0]              w_code_addr;
   logic [12:0]              w_attr_addr;
   logic                     w_last;
   logic                     w_accept;
   logic                     w_unused_inputs;

   assign w_y         = vline[7:0] + scroll_y[7:0];
   assign w_tx        = r_tx0 + r_cnt[MAP_X_BITS-1:0];
   assign w_code_addr = TX_BASE + {1'b0, r_ty, w_tx, 1'b0};
   assign w_attr_addr = w_code_addr + 13'd1;
   assign w_last      = (r_cnt == 8'(NUM_TILES - 1));
   assign w_accept    = (r_state == ST_EMIT) && tile_ready;

   assign w_unused_inputs = ^{vline[8], scroll_x[15:MAP_X_BITS+3], scroll_y[15:8]};

   always_ff @(posedge fixed_20m_clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      tile_valid  = 1'b0;
      line_done   = 1'b0;
      case (r_state)
         ST_IDLE:    if (line_start) w_state_nxt = ST_RD_CODE;
         ST_RD_CODE: w_state_nxt = ST_RD_ATTR;
         ST_RD_ATTR: w_state_nxt = ST_LATCH;
         ST_LATCH:   w_state_nxt = ST_EMIT;
         ST_EMIT: begin
            tile_valid = 1'b1;
            if (tile_ready) begin
               w_state_nxt = w_last ? ST_IDLE : ST_RD_CODE;
               line_done   = w_last && !line_start;
            end
         end
         default:    w_state_nxt = ST_IDLE;
      endcase
      // A new line_start always wins, including an abort of a line in progress.
      if (line_start) w_state_nxt = ST_RD_CODE;
   end

   always_comb begin
      case (r_state)
         ST_RD_CODE: vram_addr = w_code_addr;
         ST_RD_ATTR: vram_addr = w_attr_addr;
         default:    vram_addr = r_addr_hold;
      endcase
   end

   always_ff @(posedge fixed_20m_clk) begin
      if (!reset_n) begin
         r_ty        <= '0;
         r_row       <= '0;
         r_tx0       <= '0;
         r_fine_x    <= '0;
         r_cnt       <= '0;
         r_entry     <= '0;
         r_addr_hold <= '0;
      end else begin
         r_addr_hold <= vram_addr;
         if (line_start) begin
            r_ty     <= w_y[7:3];
            r_row    <= w_y[2:0];
            r_tx0    <= scroll_x[MAP_X_BITS+2:3];
            r_fine_x <= scroll_x[2:0];
            r_cnt    <= '0;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 8'd1;
         end
         // Read data trails the address by one cycle: code lands in RD_ATTR, attr in LATCH.
         if (r_state == ST_RD_ATTR) begin
            r_entry.code <= vram_dout;
         end
         if (r_state == ST_LATCH) begin
            r_entry.color <= vram_dout[ATTR_COLOR_MSB:ATTR_COLOR_LSB];
            r_entry.flipx <= vram_dout[ATTR_FLIPX_BIT];
`ifdef PGM_TX_FLIPY_EN
            r_entry.row   <= vram_dout[ATTR_FLIPY_BIT] ? ~r_row : r_row;
`else
            r_entry.row   <= r_row;
`endif
         end
      end
   end

   assign tile_code   = r_entry.code;
   assign tile_color  = r_entry.color;
   assign tile_flipx  = r_entry.flipx;
   assign tile_row    = r_entry.row;
   assign tile_fine_x = r_fine_x;
   assign dbg_state   = r_state;

endmodule

// File: doc/pgm_text_fetch.md
PGM_TEXT_FETCH -- requirements
Module: pgm_text_fetch

Interface
REQ-001 Parameter: TX_BASE, 13'h1000, word offset of the text tilemap inside the renderer VRAM port.
REQ-002 Parameter: NUM_TILES, 57, tile entries emitted per scanline (448 px / 8, plus 1 for fine scroll).
REQ-003 fixed_20m_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 line_start  in  1  one-cycle pulse that begins fetch for scanline vline.
REQ-006 vline  in  9  scanline number, sampled on line_start.
REQ-007 scroll_x  in  16  text layer X scroll in pixels, sampled on line_start.
REQ-008 scroll_y  in  16  text layer Y scroll in pixels, sampled on line_start.
REQ-009 vram_addr  out  13  word address to the renderer VRAM port (renderer_vram_addr).
REQ-010 vram_dout  in  16  VRAM read data, valid exactly one cycle after vram_addr.
REQ-011 tile_valid  out  1  output entry valid.
REQ-012 tile_ready  in  1  consumer accepts the entry when tile_valid && tile_ready.
REQ-013 tile_code  out  16  tile number.
REQ-014 tile_color  out  5  palette bank, attr[5:1].
REQ-015 tile_flipx  out  1  attr[6].
REQ-016 tile_row  out  3  pixel row within the tile to fetch.
REQ-017 tile_fine_x  out  3  scroll_x[2:0], held constant for the whole line.
REQ-018 line_done  out  1  one-cycle pulse after the last entry of a line is accepted.

Function
REQ-019 Map geometry: 64x32 tiles, 2 words per entry (word0 = code, word1 = attr); entry address = TX_BASE + {ty[4:0], tx[5:0], 1'b0} (+1 for attr).
REQ-020 On line_start: y = vline + scroll_y (mod 256); ty = y[7:3]; row = y[2:0]; tx0 = scroll_x[8:3]; tile counter = 0.
REQ-021 States: IDLE, RD_CODE, RD_ATTR, LATCH, EMIT; line_start in IDLE goes to RD_CODE.
REQ-022 RD_CODE drives the code address; RD_ATTR captures the code and drives the attr address; LATCH captures the attr; EMIT asserts tile_valid.
REQ-023 The outputs SHALL stay stable while tile_valid=1 && tile_ready=0.
REQ-024 On an accepted entry, the counter increments; below NUM_TILES -> RD_CODE, otherwise -> IDLE with line_done pulsed the same cycle.
REQ-025 Column index tx = (tx0 + counter) mod 64 wraps from 63 to 0 without a gap.
REQ-026 Minimum throughput: one entry per 4 cycles with tile_ready held high.
REQ-027 If line_start arrives in any non-IDLE state, the current line SHALL be aborted (no line_done), tile_valid deasserted next cycle, and the new line restarted from RD_CODE.
REQ-028 vram_addr SHALL hold its last value in IDLE.

Reset
REQ-029 reset_n=0 at a clock edge: state IDLE, tile_valid=0, line_done=0, vram_addr=0, all data outputs 0, counter 0; effective even mid-line.

Configuration
REQ-030 PGM_TX_FLIPY_EN defined: when attr[7]=1, tile_row = ~row.
REQ-031 PGM_TX_FLIPY_EN undefined: attr[7] ignored, tile_row = row; tile_flipx is unaffected.

Structure
REQ-032 Shared package pgm_video_pkg: state enum, tile entry struct (code, color, flipx, row), map width/height constants, attr bit-position constants.
REQ-033 Single module with no sub-modules; address generation stays inline.

Verification
REQ-034 VRAM[0x1000]=0x1234, [0x1001]=0x00AA; vline=0, scrolls=0, ready=1 -> first entry code 0x1234, color 0x15, flipx 0, row 0.
REQ-035 scroll_x=0x1F8 (tx0=63) -> entry 0 from column 63 and entry 1 from column 0 (word addr TX_BASE+0).
REQ-036 vline=250, scroll_y=10 -> y=4, ty=0, tile_row=4; with flipy attr set, tile_row=3 if the macro is defined, 4 if undefined.
REQ-037 tile_ready low for 5 cycles during EMIT -> outputs stable, no entry lost; 57 entries total, then a single line_done.
REQ-038 line_start injected at entry 20 -> no line_done for the aborted line; the new line delivers 57 entries.
REQ-039 reset_n low during RD_ATTR -> next cycle IDLE, tile_valid 0; the next line_start behaves normally.
